// File: rtl/morse_key_sequencer.sv
// Morse character player: keys one character of up to five dot/dash symbols on `tone`.
// Optional MORSE_CHAR_GAP_EN appends a 3-unit inter-character gap before `done`.
module morse_key_sequencer #(
    parameter int UNIT_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int MAX_SYM     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] code,
    input  logic [2:0] len,
    input  logic       abort,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_idx,
    output logic       unit_tick
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
`ifdef MORSE_CHAR_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         elem, elem_n;     // units left in the current element after this one
    logic [2:0]         idx_n, nxt_idx;
    logic [4:0]         code_q, code_n;
    logic [2:0]         len_q, len_n;
    logic               last_unit, busy_n;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        elem_n    = elem;
        idx_n     = sym_idx;
        code_n    = code_q;
        len_n     = len_q;
        nxt_idx   = sym_idx + 3'd1;
        last_unit = (cnt == CNT_W'(UNIT_CYCLES - 1));

        if (busy)
            cnt_n = last_unit ? '0 : cnt + 1'b1;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start && !abort && len != 3'd0) begin
                    code_n  = code;
                    len_n   = (len > 3'(MAX_SYM)) ? 3'(MAX_SYM) : len;
                    cnt_n   = '0;
                    idx_n   = '0;
                    elem_n  = code[0] ? 2'd2 : 2'd0;
                    state_n = MARK;
                end
            end
            MARK: begin
                if (last_unit) begin
                    if (elem != 2'd0)
                        elem_n = elem - 2'd1;
                    else if (sym_idx < len_q - 3'd1)
                        state_n = SPACE;
                    else begin
`ifdef MORSE_CHAR_GAP_EN
                        elem_n  = 2'd2;
                        state_n = GAP;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
            SPACE: begin
                if (last_unit) begin
                    idx_n   = nxt_idx;
                    elem_n  = code_q[nxt_idx] ? 2'd2 : 2'd0;
                    state_n = MARK;
                end
            end
`ifdef MORSE_CHAR_GAP_EN
            GAP: begin
                if (last_unit) begin
                    if (elem != 2'd0)
                        elem_n = elem - 2'd1;
                    else
                        state_n = DONE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Cancel overrides any tick-driven transition while playing.
        if (busy && abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end

        busy_n = (state_n != IDLE) && (state_n != DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            elem      <= '0;
            sym_idx   <= '0;
            code_q    <= '0;
            len_q     <= '0;
            tone      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            unit_tick <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            elem      <= elem_n;
            sym_idx   <= idx_n;
            code_q    <= code_n;
            len_q     <= len_n;
            tone      <= (state_n == MARK);
            busy      <= busy_n;
            done      <= (state_n == DONE);
            unit_tick <= busy_n && (cnt_n == CNT_W'(UNIT_CYCLES - 1));
        end
    end

endmodule
